// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings seen on the
// op port and the iteration FSM state encoding.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_step_core.sv
// Single iteration of the unsigned datapath: one shift-add multiply step or
// one restoring subtract-shift divide step on the 2W+1 bit accumulator.
module mult_div_unit_step_core #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0]  acc_i,
   input  logic [WIDTH-1:0]  operand_i,
   input  logic              is_div_i,
   output logic [2*WIDTH:0]  acc_o
);

   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] rem_sub;
   logic           rem_ge;

   always_comb begin
      add_sum = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
      // Divide: remainder lives in the upper half, quotient bits shift in at bit 0.
      rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
      rem_ge  = (rem_sh >= {1'b0, operand_i});
      rem_sub = rem_sh - {1'b0, operand_i};
      if (is_div_i) begin
         acc_o = rem_ge ? {rem_sub, acc_i[WIDTH-2:0], 1'b1}
                        : {rem_sh,  acc_i[WIDTH-2:0], 1'b0};
      end else begin
         acc_o = {1'b0, add_sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit plus MTHI/MTLO writes; owns the HI/LO
// registers read by the register file and raises busy while iterating.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] hi_reg,
   output logic [WIDTH-1:0] lo_reg,
   output logic             busy,
   output logic             done
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                        input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   mdu_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH:0]  acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic              is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
   logic              op_signed, a_neg, b_neg;
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [2*WIDTH-1:0] product;

   mult_div_unit_step_core #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .is_div_i  (is_div_q),
      .acc_o     (acc_step)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      op_signed = (op == MDU_MULT) || (op == MDU_DIV);
      a_neg     = op_signed & operand_a[WIDTH-1];
      b_neg     = op_signed & operand_b[WIDTH-1];
      mag_a     = magnitude(operand_a, op_signed);
      mag_b     = magnitude(operand_b, op_signed);
      product   = cond_neg_wide(acc_q[2*WIDTH-1:0], neg_q);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     state_d  = ST_RUN;
                     busy_d   = 1'b1;
                     cnt_d    = '0;
                     is_div_d = 1'b0;
                     div0_d   = 1'b0;
                     opnd_d   = mag_a;
                     acc_d    = {{(WIDTH+1){1'b0}}, mag_b};
                     neg_d    = a_neg ^ b_neg;
                     neg_rem_d = a_neg;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state_d  = ST_RUN;
                     busy_d   = 1'b1;
                     cnt_d    = '0;
                     is_div_d = 1'b1;
                     div0_d   = (operand_b == '0);
                     opnd_d   = mag_b;
                     acc_d    = {{(WIDTH+1){1'b0}}, mag_a};
                     neg_d    = a_neg ^ b_neg;
                     neg_rem_d = a_neg;
                  end
                  MDU_MTHI: hi_d = operand_a;
                  MDU_MTLO: lo_d = operand_a;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER-1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // A zero divisor leaves the dividend magnitude as remainder, so only LO needs overriding.
            if (is_div_q) begin
               lo_d = div0_q ? '1 : cond_neg(acc_q[WIDTH-1:0], neg_q);
               hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
            end else begin
               hi_d = product[2*WIDTH-1:WIDTH];
               lo_d = product[WIDTH-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
   end

   assign hi_reg = hi_q;
   assign lo_reg = lo_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit with a plain-arithmetic
// reference model of HI/LO.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, busy, done;
   logic [2:0]   op;
   logic [W-1:0] a, b, hi, lo;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .operand_a (a),
      .operand_b (b),
      .hi_reg    (hi),
      .lo_reg    (lo),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; pulses start for one edge and returns at the next negedge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo);
      int n;
      issue(o, x, y);
      wait_done(n);
      check({tag, " busy_cycles"}, W'(n), 32'd33);
      check({tag, " done"}, {31'b0, done}, 32'd1);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
   endtask

   function automatic void model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 inout logic [W-1:0] mh, inout logic [W-1:0] ml);
      longint      sx, sy, sv;
      logic [63:0] ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (o)
         MDU_MULT:  begin sv = sx * sy; p = sv; mh = p[63:32]; ml = p[31:0]; end
         MDU_MULTU: begin p = ux * uy; mh = p[63:32]; ml = p[31:0]; end
         MDU_DIV: begin
            if (y == 0) begin ml = '1; mh = x; end
            else begin
               sv = sx / sy; p = sv; ml = p[31:0];
               sv = sx % sy; p = sv; mh = p[31:0];
            end
         end
         MDU_DIVU: begin
            if (y == 0) begin ml = '1; mh = x; end
            else begin
               p = ux / uy; ml = p[31:0];
               p = ux % uy; mh = p[31:0];
            end
         end
         MDU_MTHI: mh = x;
         MDU_MTLO: ml = x;
         default: ;
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(1, 16));
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int           n, seen;
      logic [2:0]   o;
      logic [W-1:0] x, y, mh, ml;

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("mult_7_m3", MDU_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      @(negedge clk);
      check("mult done_width", {31'b0, done}, 32'd0);
      check("mult busy_after", {31'b0, busy}, 32'd0);
      check("mult hold_hi", hi, 32'hFFFF_FFFF);

      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_by0", MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
      run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op("div_m9_by0", MDU_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

      issue(MDU_MTHI, 32'h1234, 32'h0);
      check("mthi hi", hi, 32'h1234);
      check("mthi lo_kept", lo, 32'hFFFF_FFFF);
      check("mthi busy", {31'b0, busy}, 32'd0);
      check("mthi done", {31'b0, done}, 32'd0);

      issue(MDU_MULT, 32'd5, 32'd6);
      repeat (9) @(negedge clk);
      issue(MDU_MTLO, 32'hDEAD_BEEF, 32'h0);
      check("mtlo_ignored lo_mid", lo, 32'hFFFF_FFFF);
      wait_done(n);
      check("mtlo_ignored busy_rest", W'(n), 32'd23);
      check("mtlo_ignored hi", hi, 32'h0);
      check("mtlo_ignored lo", lo, 32'd30);

      issue(MDU_DIVU, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort hi", hi, 32'h0);
      check("abort lo", lo, 32'h0);
      check("abort busy", {31'b0, busy}, 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done !== 1'b0) seen++;
         @(negedge clk);
      end
      check("abort no_done", W'(seen), 32'd0);
      run_op("mult_3_4", MDU_MULT, 32'd3, 32'd4, 32'h0, 32'd12);

      run_op("b2b_multu", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);
      run_op("b2b_divu", MDU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF);

      mh = 32'hF;
      ml = 32'h0FFF_FFFF;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 5));
         x = pick();
         y = pick();
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            check("rand hold_hi", hi, mh);
            check("rand hold_lo", lo, ml);
         end
         model(o, x, y, mh, ml);
         if (o == MDU_MTHI || o == MDU_MTLO) begin
            issue(o, x, y);
            check("rand mt_hi", hi, mh);
            check("rand mt_lo", lo, ml);
            check("rand mt_busy", {31'b0, busy}, 32'd0);
         end else begin
            run_op("rand", o, x, y, mh, ml);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
